// File: rtl/srcnn_frame_controller.sv
// ---------------------------------------------------------------------------
// srcnn_frame_controller
//
// Runs the srcnn_small streaming pipeline one frame at a time. A start command
// opens the input gate for exactly Height*Width pixels. The pipeline output is
// then counted back out to the sink and tagged with sof/eol/eof markers. A
// single done pulse follows the last accepted output pixel.
//
// Ports
//   clock_i, reset_i         : clock, synchronous active-high reset
//   start_i                  : frame start, only honoured in IDLE
//   busy_o, done_o, error_o  : frame in flight, completion pulse, sticky
//                              "pipeline output outside a frame" flag
//   up_*                     : upstream source -> controller
//   pipe_valid_o/ready_i/data_o : controller -> pipeline slave port
//   pipe_valid_i/ready_o/data_i : pipeline master port -> controller
//   down_*                   : controller -> downstream sink, with markers
//
// State table
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | no frame; all streams gated, waiting for start_i
//   ST_RUN   | input and output paths both open, counting input pixels
//   ST_DRAIN | all input pixels admitted; only the output path is open
//   ST_DONE  | eof pixel accepted; done_o high for this one cycle
// ---------------------------------------------------------------------------
module srcnn_frame_controller #(
  parameter  int Height          = 480,
  parameter  int Width           = 640,
  localparam int ActivationWidth = 10,
  localparam int PixelWidth      = 3 * ActivationWidth,
  localparam int CountWidth      = $clog2(Height * Width + 1)
) (
  input  logic                  clock_i,
  input  logic                  reset_i,

  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,

  input  logic                  up_valid_i,
  output logic                  up_ready_o,
  input  logic [PixelWidth-1:0] up_data_i,

  output logic                  pipe_valid_o,
  input  logic                  pipe_ready_i,
  output logic [PixelWidth-1:0] pipe_data_o,

  input  logic                  pipe_valid_i,
  output logic                  pipe_ready_o,
  input  logic [PixelWidth-1:0] pipe_data_i,

  output logic                  down_valid_o,
  input  logic                  down_ready_i,
  output logic [PixelWidth-1:0] down_data_o,
  output logic                  down_sof_o,
  output logic                  down_eol_o,
  output logic                  down_eof_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [CountWidth-1:0] LastPixel = CountWidth'(Height * Width - 1);
  localparam logic [CountWidth-1:0] LastCol   = CountWidth'(Width - 1);
  localparam logic [CountWidth-1:0] LastRow   = CountWidth'(Height - 1);
  localparam logic [CountWidth-1:0] CountOne  = CountWidth'(1);

  state_t                  state_q, state_d;
  logic [CountWidth-1:0]   in_count_q, in_count_d;
  logic [CountWidth-1:0]   out_row_q, out_row_d;
  logic [CountWidth-1:0]   out_col_q, out_col_d;
  logic                    error_q, error_d;

  logic                    in_open;
  logic                    out_open;
  logic                    in_hs;
  logic                    out_hs;
  logic                    sof;
  logic                    eol;
  logic                    eof;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      in_count_q <= '0;
      out_row_q  <= '0;
      out_col_q  <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_count_q <= in_count_d;
      out_row_q  <= out_row_d;
      out_col_q  <= out_col_d;
      error_q    <= error_d;
    end
  end

  // Stream gating depends only on registered state, so no combinational
  // path exists between the upstream and downstream handshakes.
  always_comb begin
    in_open  = (state_q == ST_RUN);
    out_open = (state_q == ST_RUN) || (state_q == ST_DRAIN);

    in_hs  = in_open  && up_valid_i   && pipe_ready_i;
    out_hs = out_open && pipe_valid_i && down_ready_i;

    sof = (out_row_q == '0) && (out_col_q == '0);
    eol = (out_col_q == LastCol);
    eof = eol && (out_row_q == LastRow);
  end

  always_comb begin
    state_d    = state_q;
    in_count_d = in_count_q;
    out_row_d  = out_row_q;
    out_col_d  = out_col_q;
    error_d    = error_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          in_count_d = '0;
          out_row_d  = '0;
          out_col_d  = '0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (in_hs) begin
          in_count_d = in_count_q + CountOne;
          if (in_count_q == LastPixel) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_DRAIN;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Output counting runs alongside the input side; an eof handshake wins
    // over a simultaneous RUN->DRAIN move since the frame is then finished.
    if (out_hs) begin
      if (eol) begin
        out_col_d = '0;
        out_row_d = eof ? '0 : (out_row_q + CountOne);
      end else begin
        out_col_d = out_col_q + CountOne;
      end
      if (eof) begin
        state_d = ST_DONE;
      end
    end

    if (!out_open && pipe_valid_i) begin
      error_d = 1'b1;
    end
  end

  assign up_ready_o   = in_open && pipe_ready_i;
  assign pipe_valid_o = in_open && up_valid_i;
  assign pipe_data_o  = up_data_i;

  assign down_valid_o = out_open && pipe_valid_i;
  assign pipe_ready_o = out_open && down_ready_i;
  assign down_data_o  = pipe_data_i;
  assign down_sof_o   = sof;
  assign down_eol_o   = eol;
  assign down_eof_o   = eof;

  assign busy_o  = out_open;
  assign done_o  = (state_q == ST_DONE);
  assign error_o = error_q;

endmodule
